// File: rtl/mux_n_sel_reg_if.sv
// -----------------------------------------------------------------------------
// mux_n_sel_reg_if
// Bundle of producer-side and consumer-side signals around the N-way
// registered selector.
//   in_data   N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid  N        per-channel word available
//   in_ready  N        per-channel accept strobe (one-hot or zero)
//   sel       SW       fixed channel index used when mode=0
//   mode      1        0 = fixed select, 1 = round-robin
//   out_data  WIDTH    registered selected word
//   out_ch    SW       channel that produced out_data
//   out_valid 1        output stage holds a word
//   out_ready 1        consumer accepts the word this cycle
//   out_par   1        even parity of out_data (0 when parity is not built)
// Modports: master = environment (producers + consumer), slave = selector.
// -----------------------------------------------------------------------------
interface mux_n_sel_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 1,
  parameter int SW    = 2
) ();
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SW-1:0]      sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               out_par;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_par
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_par
  );
endinterface

// File: rtl/mux_n_sel_reg.sv
// -----------------------------------------------------------------------------
// mux_n_sel_reg
// N-way, WIDTH-bit registered selector with per-channel valid/ready and a
// one-entry output stage with downstream backpressure. The channel is chosen
// either by a fixed index (mode=0) or by a round-robin scan over the valid
// channels starting at an internal pointer (mode=1).
//
// Ports
//   clk_i    rising-edge clock
//   rst_n_i  synchronous reset, active low
//   bus      mux_n_sel_reg_if.slave (data/valid/ready for inputs and output,
//            sel, mode, out_par)
//
// Optional feature
//   MUXN_PARITY_EN  when defined, a registered even-parity bit of the loaded
//                   word is provided on out_par; otherwise out_par is tied 0.
// -----------------------------------------------------------------------------
module mux_n_sel_reg #(
  parameter int N     = 4,
  parameter int WIDTH = 1,
  parameter int SW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  mux_n_sel_reg_if.slave     bus
);

  // N widened by one bit so that any SW-bit index can be compared against it,
  // which matters when N is not a power of two.
  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_ch_q,   out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    rr_ptr_q,   rr_ptr_d;

  logic [WIDTH-1:0] ch_data [N];
  logic [SW-1:0]    rr_idx  [N];

  logic             cand_ok;
  logic [SW-1:0]    cand_ch;
  logic             free;
  logic             xfer;
  logic [N-1:0]     in_ready_c;

  // Per-channel word slicing and the scan order for round-robin:
  // rr_idx[gi] is the channel visited at offset gi from the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [SW:0] sum;
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      assign sum         = {1'b0, rr_ptr_q} + (SW+1)'(gi);
      // Pointer and offset are both < N, so one conditional subtract wraps.
      assign rr_idx[gi]  = (sum >= N_EXT) ? SW'(sum - N_EXT) : sum[SW-1:0];
    end
  endgenerate

  // Candidate selection. In round-robin the loop runs from the far end so the
  // lowest offset with a valid bit is the last one written and wins.
  always_comb begin
    cand_ok = 1'b0;
    cand_ch = '0;
    if (!bus.mode) begin
      cand_ok = ({1'b0, bus.sel} < N_EXT);
      cand_ch = bus.sel;
    end else begin
      for (int i = N-1; i >= 0; i--) begin
        if (bus.in_valid[rr_idx[i]]) begin
          cand_ok = 1'b1;
          cand_ch = rr_idx[i];
        end
      end
    end
  end

  assign free = ~out_valid_q | bus.out_ready;
  // In fixed mode only the selected channel's valid bit reaches xfer.
  assign xfer = rst_n_i & cand_ok & bus.in_valid[cand_ch] & free;

  always_comb begin
    in_ready_c = '0;
    if (xfer) begin
      in_ready_c[cand_ch] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      // A draining word and a new accept share the edge: no bubble.
      out_data_d  = ch_data[cand_ch];
      out_ch_d    = cand_ch;
      out_valid_d = 1'b1;
      if (bus.mode) begin
        rr_ptr_d = (cand_ch == LAST_CH) ? '0 : cand_ch + SW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef MUXN_PARITY_EN
  logic out_par_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_par_q <= 1'b0;
    end else if (xfer) begin
      out_par_q <= ^ch_data[cand_ch];
    end
  end

  assign bus.out_par = out_par_q;
`else
  assign bus.out_par = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule
